// File: rtl/soc_sonhamos_pkg.sv
// CGRA peripheral window: base/size, register offsets, field bit positions and
// the controller FSM state type.
package soc_sonhamos_pkg;

    localparam logic [31:0] CGRA_PERIPH_START_ADDRESS = 32'h2000_3000;
    localparam logic [31:0] CGRA_PERIPH_SIZE          = 32'h0000_1000;

    localparam logic [11:0] CGRA_CTRL_OFFSET      = 12'h000;
    localparam logic [11:0] CGRA_STATUS_OFFSET    = 12'h004;
    localparam logic [11:0] CGRA_KERNEL_ID_OFFSET = 12'h008;
    localparam logic [11:0] CGRA_CYCLES_OFFSET    = 12'h00C;
    localparam logic [11:0] CGRA_PTR_BASE_OFFSET  = 12'h010;

    localparam int unsigned CGRA_CTRL_START_BIT   = 0;
    localparam int unsigned CGRA_CTRL_IRQ_EN_BIT  = 1;
    localparam int unsigned CGRA_STATUS_BUSY_BIT  = 0;
    localparam int unsigned CGRA_STATUS_DONE_BIT  = 1;

    typedef enum logic [1:0] {
        CGRA_IDLE  = 2'd0,
        CGRA_START = 2'd1,
        CGRA_BUSY  = 2'd2
    } cgra_state_e;

endpackage

// File: rtl/cgra_cycle_counter.sv
// Saturating cycle counter with synchronous clear; holds when not enabled.
module cgra_cycle_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg <= '0;
        end else if (clear_i) begin
            count_reg <= '0;
        end else if (en_i && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_o = count_reg;

endmodule

// File: rtl/cgra_periph_ctrl.sv
// Register front-end and kernel launch sequencer for the CGRA: zero-wait-state
// register bus, start/busy/done handshake, cycle measurement and done interrupt.
module cgra_periph_ctrl
    import soc_sonhamos_pkg::*;
#(
    parameter int N_PTR = 4,
    parameter int DW    = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 reg_valid_i,
    input  logic                 reg_write_i,
    input  logic [11:0]          reg_addr_i,
    input  logic [DW-1:0]        reg_wdata_i,
    output logic                 reg_ready_o,
    output logic [DW-1:0]        reg_rdata_o,
    output logic                 reg_error_o,
    output logic                 cgra_start_o,
    output logic [7:0]           cgra_kernel_id_o,
    output logic [N_PTR*32-1:0]  cgra_ptr_o,
    input  logic                 cgra_done_i,
    output logic                 cgra_irq_o
);

    cgra_state_e  state_reg, state_next;
    logic         busy, cnt_clear, cnt_en;
    logic         irq_en_reg, irq_en_next;
    logic         done_reg, done_next;
    logic         irq_reg;
    logic [7:0]   kernel_reg;
    logic [31:0]  ptr_reg [N_PTR];
    logic [31:0]  cycles;
    logic [31:0]  wdata32, rdata32;

    // Address decode: word-aligned offsets only, PTR window sized by N_PTR.
    logic        aligned, hit_ctrl, hit_status, hit_kernel, hit_cycles, hit_ptr, addr_err;
    logic [9:0]  word, ptr_idx;
    logic        wr_en, start_req;

    assign wdata32    = 32'(reg_wdata_i);
    assign aligned    = (reg_addr_i[1:0] == 2'b00);
    assign word       = reg_addr_i[11:2];
    assign ptr_idx    = word - CGRA_PTR_BASE_OFFSET[11:2];
    assign hit_ctrl   = aligned && (reg_addr_i == CGRA_CTRL_OFFSET);
    assign hit_status = aligned && (reg_addr_i == CGRA_STATUS_OFFSET);
    assign hit_kernel = aligned && (reg_addr_i == CGRA_KERNEL_ID_OFFSET);
    assign hit_cycles = aligned && (reg_addr_i == CGRA_CYCLES_OFFSET);
    assign hit_ptr    = aligned && (word >= CGRA_PTR_BASE_OFFSET[11:2])
                                && (ptr_idx < 10'(N_PTR));
    assign addr_err   = !(hit_ctrl || hit_status || hit_kernel || hit_cycles || hit_ptr);

    assign wr_en      = reg_valid_i && reg_write_i && !addr_err;
    assign start_req  = wr_en && hit_ctrl && wdata32[CGRA_CTRL_START_BIT]
                        && (state_reg == CGRA_IDLE);

    assign reg_ready_o = reg_valid_i;
    assign reg_error_o = reg_valid_i && addr_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_reg <= CGRA_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CGRA_IDLE:  if (start_req) state_next = CGRA_START;
            CGRA_START: state_next = CGRA_BUSY;
            CGRA_BUSY:  if (cgra_done_i) state_next = CGRA_IDLE;
            default:    state_next = CGRA_IDLE;
        endcase
    end

    always_comb begin
        cgra_start_o = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        busy         = 1'b1;
        case (state_reg)
            CGRA_START: begin
                cgra_start_o = 1'b1;
                cnt_clear    = 1'b1;
            end
            CGRA_BUSY:  cnt_en = 1'b1;
            default:    busy = 1'b0;
        endcase
    end

    // A done arriving in BUSY wins over a simultaneous write-1-to-clear.
    always_comb begin
        irq_en_next = irq_en_reg;
        if (wr_en && hit_ctrl) irq_en_next = wdata32[CGRA_CTRL_IRQ_EN_BIT];
        done_next = done_reg;
        if (wr_en && hit_status && wdata32[CGRA_STATUS_DONE_BIT]) done_next = 1'b0;
        if ((state_reg == CGRA_BUSY) && cgra_done_i) done_next = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_reg <= 1'b0;
            done_reg   <= 1'b0;
            irq_reg    <= 1'b0;
            kernel_reg <= '0;
        end else begin
            irq_en_reg <= irq_en_next;
            done_reg   <= done_next;
            irq_reg    <= done_next && irq_en_next;
            if (wr_en && hit_kernel && !busy) kernel_reg <= wdata32[7:0];
        end
    end

    // Pointers are frozen for the whole run so the CGRA sees stable bases.
    for (genvar gi = 0; gi < N_PTR; gi++) begin : g_ptr
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                ptr_reg[gi] <= '0;
            end else if (wr_en && hit_ptr && (ptr_idx == 10'(gi)) && !busy) begin
                ptr_reg[gi] <= wdata32;
            end
        end
        assign cgra_ptr_o[gi*32 +: 32] = ptr_reg[gi];
    end

    cgra_cycle_counter #(.W(32)) u_cycles (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (cnt_clear),
        .en_i    (cnt_en),
        .count_o (cycles)
    );

    always_comb begin
        rdata32 = '0;
        if (hit_ctrl)   rdata32[CGRA_CTRL_IRQ_EN_BIT] = irq_en_reg;
        if (hit_status) begin
            rdata32[CGRA_STATUS_BUSY_BIT] = busy;
            rdata32[CGRA_STATUS_DONE_BIT] = done_reg;
        end
        if (hit_kernel) rdata32[7:0] = kernel_reg;
        if (hit_cycles) rdata32 = cycles;
        for (int i = 0; i < N_PTR; i++) begin
            if (hit_ptr && (ptr_idx == 10'(i))) rdata32 = ptr_reg[i];
        end
    end

    assign reg_rdata_o      = DW'(rdata32);
    assign cgra_kernel_id_o = kernel_reg;
    assign cgra_irq_o       = irq_reg;

endmodule
